alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//  Parametrised successor to the single-cycle ALU datapath: executes alu_functions_t codes plus
//  the new FnASR/FnXOR/FnSUC on WIDTH-bit operands and owns the architectural Z/C/V/N register.
//  Shifts are multi-bit and iterative, one bit per cycle, under a Start/Busy/Done handshake.
//  Sits between the datapath operand muxes (Op1/Op2 selects) and the Wd write-back mux.
// PARAMETERS
//  WIDTH    16               operand/result width; power of two, >= 4
//  SHIFT_W  $clog2(WIDTH)    width of ShAmt
// PORTS
//  Clock     in   1        single clock, rising edge
//  nReset    in   1        asynchronous, active-low reset
//  Start     in   1        begin operation Fn; accepted only when Busy=0
//  Fn        in   4        FnNOP=0 ACC=1 ADC=2 MEM=3 IMM=4 ADD=5 SUB=6 AND=7 OR=8 NOT=9 LSL=10 LSR=11 ASR=12 XOR=13 SUC=14
//  A         in   WIDTH    operand 1 (shift source)
//  B         in   WIDTH    operand 2
//  ShAmt     in   SHIFT_W  shift distance for LSL/LSR/ASR
//  Flush     in   1        synchronous abort of the operation in flight
//  FlagsWe   in   1        load Flags from FlagsIn (ignored while Busy)
//  FlagsIn   in   4        restore value, indexed FLAGS_Z=0 C=1 V=2 N=3
//  Result    out  WIDTH    registered result of the last completed operation
//  Flags     out  4        registered Z/C/V/N
//  Busy      out  1        operation in flight; Start ignored
//  Done      out  1        one-cycle pulse: Result/Flags just updated
// BEHAVIOUR
//  - Reset (async, nReset=0): Result=0, Flags=0, Busy=0, Done=0, state IDLE, shift count 0.
//  - FSM IDLE -> EXEC (all non-shift Fn, and shifts with ShAmt=0) -> IDLE; IDLE -> SHIFT -> IDLE.
//  - Start sampled at edge 0 with operands/Fn/ShAmt captured; operands may change afterwards.
//  - Non-shift op: Result/Flags valid and Done=1 in the cycle after edge 1; Busy=1 for that one
//    cycle only if a further Start would collide (EXEC issues no Busy; back-to-back Start allowed).
//  - Shift, ShAmt=N>=1: Busy=1 from edge 0 to edge N; one bit per cycle; Done after edge N.
//    ShAmt=0: behaves as EXEC, Result=A, C unchanged, V=0.
//  - Arithmetic (WIDTH+1-bit sum): ADD A+B; ADC A+B+C; SUB A+~B+1; SUC A+~B+C.
//    C = carry out of the sum (SUB: C=1 means no borrow); V = signed overflow of the sum.
//  - Logic AND/OR/XOR/NOT(~A): C unchanged, V=0. Shifts: LSL/LSR fill 0, ASR fills A[MSB];
//    C = last bit shifted out, V=0.
//  - Z = (Result==0), N = Result[WIDTH-1] for all arithmetic/logic/shift ops.
//  - ACC -> Result=A, MEM/IMM -> Result=B: flags unchanged. NOP and Fn=15: Result and flags
//    unchanged, Done still pulses.
//  - Carry-in for ADC/SUC is Flags[C] as held at edge 0.
//  - Start while Busy: ignored, no side effect. FlagsWe while Busy: ignored.
//  - FlagsWe with Start (Busy=0): Flags<=FlagsIn at edge 0; the op uses the old C; its completion
//    overwrites only the fields it updates.
//  - Flush: at next edge state->IDLE, Busy=0, no Done, Result/Flags keep pre-op values.
//    Flush with Start in the same cycle: Flush wins, Start dropped.
//  - Reset mid-operation: immediate return to reset values; no Done.
// TESTING
//  1 nReset=0 at any point -> Result=0, Flags=4'b0000, Busy=0, Done=0 without a clock edge.
//  2 ADD A=16'h7FFF B=16'h0001 -> next cycle Result=16'h8000, N=1 V=1 C=0 Z=0, Done one pulse.
//  3 SUB A=5 B=5 -> Result=0, Z=1 C=1; then SUC A=0 B=0 -> Result=0 (C=1); redo with C=0 -> 16'hFFFF, N=1 C=0.
//  4 ASR A=16'h8001 ShAmt=3 -> Busy 3 cycles, Result=16'hF000, C=0; LSL A=16'h8001 ShAmt=1 -> 16'h0002, C=1.
//  5 LSR ShAmt=8, Start again at cycle 2 (ignored), Flush at cycle 3 -> Busy low next cycle, no Done, Result unchanged.
//  6 FlagsWe=1 FlagsIn=4'b0010 with Start ADC A=1 B=1 (old C=0) -> Result=2, Flags Z=0 C=0 V=0 N=0.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Sequential ALU with Z/C/V/N flag register.
// Non-shift ops complete in one cycle; shifts move one bit per cycle.
module alu_seq_unit #(
    parameter int WIDTH   = 16,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic               Start,
    input  logic [3:0]         Fn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHIFT_W-1:0] ShAmt,
    input  logic               Flush,
    input  logic               FlagsWe,
    input  logic [3:0]         FlagsIn,
    output logic [WIDTH-1:0]   Result,
    output logic [3:0]         Flags,
    output logic               Busy,
    output logic               Done
);

    localparam int FLAGS_Z = 0;
    localparam int FLAGS_C = 1;
    localparam int FLAGS_V = 2;
    localparam int FLAGS_N = 3;

    typedef enum logic [3:0] {
        FN_NOP = 4'd0,
        FN_ACC = 4'd1,
        FN_ADC = 4'd2,
        FN_MEM = 4'd3,
        FN_IMM = 4'd4,
        FN_ADD = 4'd5,
        FN_SUB = 4'd6,
        FN_AND = 4'd7,
        FN_OR  = 4'd8,
        FN_NOT = 4'd9,
        FN_LSL = 4'd10,
        FN_LSR = 4'd11,
        FN_ASR = 4'd12,
        FN_XOR = 4'd13,
        FN_SUC = 4'd14,
        FN_RSV = 4'd15
    } alu_fn_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT
    } state_e;

    state_e             state_q;
    alu_fn_e            fn_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               cin_q;
    logic [WIDTH-1:0]   sh_q;
    logic [SHIFT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q;
    logic               busy_q;
    logic               done_q;

    logic               start_ok;
    logic               in_is_sh;
    logic               go_sh;
    logic               cmp_c;
    logic [WIDTH-1:0]   bx;
    logic               ci;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sh_nx;
    logic               sh_out;
    logic [WIDTH-1:0]   res_c;
    logic [3:0]         val_c;
    logic [3:0]         msk_c;
    logic [3:0]         fl_base;
    logic [3:0]         flags_d;

    // Start acceptance: Flush always wins, Busy blocks new work
    always_comb begin
        start_ok = Start && !busy_q && !Flush;
        in_is_sh = (Fn == FN_LSL) || (Fn == FN_LSR) || (Fn == FN_ASR);
        go_sh    = start_ok && in_is_sh && (ShAmt != '0);
    end

    // One-bit shift step of the working register
    always_comb begin
        sh_nx  = sh_q;
        sh_out = 1'b0;
        case (fn_q)
            FN_LSL: begin
                sh_nx  = {sh_q[WIDTH-2:0], 1'b0};
                sh_out = sh_q[WIDTH-1];
            end
            FN_LSR: begin
                sh_nx  = {1'b0, sh_q[WIDTH-1:1]};
                sh_out = sh_q[0];
            end
            FN_ASR: begin
                sh_nx  = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                sh_out = sh_q[0];
            end
            default: begin
                sh_nx  = sh_q;
                sh_out = 1'b0;
            end
        endcase
    end

    // Completion result and flag update mask for the op in flight
    always_comb begin
        bx    = ((fn_q == FN_SUB) || (fn_q == FN_SUC)) ? ~b_q : b_q;
        ci    = 1'b0;
        if (fn_q == FN_SUB)
            ci = 1'b1;
        else if ((fn_q == FN_ADC) || (fn_q == FN_SUC))
            ci = cin_q;
        sum   = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};
        res_c = result_q;
        val_c = 4'b0000;
        msk_c = 4'b0000;
        case (fn_q)
            FN_ACC: res_c = a_q;
            FN_MEM, FN_IMM: res_c = b_q;
            FN_ADD, FN_ADC, FN_SUB, FN_SUC: begin
                res_c          = sum[WIDTH-1:0];
                val_c[FLAGS_C] = sum[WIDTH];
                val_c[FLAGS_V] = (a_q[WIDTH-1] == bx[WIDTH-1]) &&
                                 (sum[WIDTH-1] != a_q[WIDTH-1]);
                msk_c          = 4'b1111;
            end
            FN_AND: begin
                res_c = a_q & b_q;
                msk_c = 4'b1101;
            end
            FN_OR: begin
                res_c = a_q | b_q;
                msk_c = 4'b1101;
            end
            FN_XOR: begin
                res_c = a_q ^ b_q;
                msk_c = 4'b1101;
            end
            FN_NOT: begin
                res_c = ~a_q;
                msk_c = 4'b1101;
            end
            FN_LSL, FN_LSR, FN_ASR: begin
                res_c = a_q;
                msk_c = 4'b1101;
            end
            default: begin
                res_c = result_q;
                msk_c = 4'b0000;
            end
        endcase
        if (state_q == S_SHIFT) begin
            res_c          = sh_nx;
            val_c[FLAGS_C] = sh_out;
            val_c[FLAGS_V] = 1'b0;
            msk_c          = 4'b1111;
        end
        val_c[FLAGS_Z] = (res_c == '0);
        val_c[FLAGS_N] = res_c[WIDTH-1];
        cmp_c = !Flush &&
                ((state_q == S_EXEC) ||
                 ((state_q == S_SHIFT) && (cnt_q == SHIFT_W'(1))));
        if (!cmp_c)
            msk_c = 4'b0000;
        fl_base = (FlagsWe && !busy_q) ? FlagsIn : flags_q;
        flags_d = (fl_base & ~msk_c) | (val_c & msk_c);
    end

    // Control FSM with registered Result/Flags/Busy/Done
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            fn_q     <= FN_NOP;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            flags_q <= flags_d;
            if (cmp_c) begin
                result_q <= res_c;
                done_q   <= 1'b1;
            end
            case (state_q)
                S_SHIFT: begin
                    if (Flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        sh_q  <= sh_nx;
                        cnt_q <= cnt_q - SHIFT_W'(1);
                        if (cnt_q == SHIFT_W'(1)) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (start_ok) begin
                        fn_q  <= alu_fn_e'(Fn);
                        a_q   <= A;
                        b_q   <= B;
                        cin_q <= flags_q[FLAGS_C];
                        if (go_sh) begin
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                            cnt_q   <= ShAmt;
                            sh_q    <= A;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign Result = result_q;
    assign Flags  = flags_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_seq_unit;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int MSK = (1 << W) - 1;

    logic          Clock = 1'b0;
    logic          nReset;
    logic          Start;
    logic [3:0]    Fn;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [SW-1:0] ShAmt;
    logic          Flush;
    logic          FlagsWe;
    logic [3:0]    FlagsIn;
    logic [W-1:0]  Result;
    logic [3:0]    Flags;
    logic          Busy;
    logic          Done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_res;
    logic [3:0]   m_fl;

    alu_seq_unit #(.WIDTH(W), .SHIFT_W(SW)) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .Start   (Start),
        .Fn      (Fn),
        .A       (A),
        .B       (B),
        .ShAmt   (ShAmt),
        .Flush   (Flush),
        .FlagsWe (FlagsWe),
        .FlagsIn (FlagsIn),
        .Result  (Result),
        .Flags   (Flags),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    // Reference: apply one op to the model's Result/Flags
    task automatic model(input int fn, input int a, input int b,
                         input int sh, input bit we, input logic [3:0] fin);
        bit cin;
        bit upd;
        int bb, c0, tot, sv;
        cin = m_fl[1];
        upd = 1'b0;
        if (we) m_fl = fin;
        case (fn)
            1: m_res = W'(a);
            3, 4: m_res = W'(b);
            2, 5, 6, 14: begin
                bb  = (fn == 6 || fn == 14) ? (~b & MSK) : b;
                c0  = (fn == 5) ? 0 : (fn == 6) ? 1 : int'(cin);
                tot = a + bb + c0;
                sv  = sx(a) + sx(bb) + c0;
                m_res   = W'(tot & MSK);
                m_fl[1] = (tot >> W) & 1;
                m_fl[2] = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
                upd = 1'b1;
            end
            7, 8, 9, 13: begin
                if (fn == 7) m_res = W'(a & b);
                else if (fn == 8) m_res = W'(a | b);
                else if (fn == 13) m_res = W'(a ^ b);
                else m_res = W'(~a & MSK);
                m_fl[2] = 1'b0;
                upd = 1'b1;
            end
            10, 11, 12: begin
                if (sh == 0) begin
                    m_res = W'(a);
                end else if (fn == 10) begin
                    m_res   = W'((a << sh) & MSK);
                    m_fl[1] = (a >> (W - sh)) & 1;
                end else if (fn == 11) begin
                    m_res   = W'(a >> sh);
                    m_fl[1] = (a >> (sh - 1)) & 1;
                end else begin
                    m_res   = W'((sx(a) >>> sh) & MSK);
                    m_fl[1] = (a >> (sh - 1)) & 1;
                end
                m_fl[2] = 1'b0;
                upd = 1'b1;
            end
            default: ;
        endcase
        if (upd) begin
            m_fl[0] = (m_res == 0);
            m_fl[3] = m_res[W-1];
        end
    endtask

    // Issue one op and follow it to its Done pulse
    task automatic run_op(input string tag, input int fn, input int a,
                          input int b, input int sh, input bit we,
                          input logic [3:0] fin);
        int  lat;
        bit  sbusy;
        @(negedge Clock);
        Fn = 4'(fn); A = W'(a); B = W'(b); ShAmt = SW'(sh);
        FlagsWe = we; FlagsIn = fin; Start = 1'b1;
        model(fn, a, b, sh, we, fin);
        sbusy = (fn >= 10 && fn <= 12 && sh != 0);
        lat   = sbusy ? sh : 1;
        @(posedge Clock); #1;
        Start = 1'b0; FlagsWe = 1'b0;
        A = W'($urandom); B = W'($urandom); FlagsIn = 4'($urandom);
        for (int k = 1; k <= lat; k++) begin
            chk({tag, " busy"}, Busy, sbusy);
            @(posedge Clock); #1;
            if (k < lat) chk({tag, " early done"}, Done, 0);
        end
        chk({tag, " done"}, Done, 1);
        chk({tag, " result"}, Result, m_res);
        chk({tag, " flags"}, Flags, m_fl);
        chk({tag, " busy end"}, Busy, 0);
    endtask

    task automatic load_flags(input logic [3:0] f);
        @(negedge Clock);
        FlagsWe = 1'b1; FlagsIn = f;
        @(posedge Clock); #1;
        FlagsWe = 1'b0;
        m_fl = f;
        chk("flag load", Flags, m_fl);
    endtask

    initial begin
        logic [W-1:0] pre_r;
        logic [3:0]   pre_f;
        logic [W-1:0] r1;
        logic [3:0]   f1;
        nReset = 1'b0; Start = 1'b0; Fn = '0; A = '0; B = '0;
        ShAmt = '0; Flush = 1'b0; FlagsWe = 1'b0; FlagsIn = '0;
        m_res = '0; m_fl = '0;
        #1;
        chk("rst result", Result, 0);
        chk("rst flags", Flags, 0);
        chk("rst busy", Busy, 0);
        chk("rst done", Done, 0);
        #12 nReset = 1'b1;

        run_op("add ovf", 5, 'h7FFF, 'h0001, 0, 0, 0);
        chk("add flags nvcz", Flags, 4'b1100);
        @(posedge Clock); #1;
        chk("add done pulse", Done, 0);

        run_op("sub eq", 6, 5, 5, 0, 0, 0);
        chk("sub z c", Flags, 4'b0011);
        run_op("suc c1", 14, 0, 0, 0, 0, 0);
        chk("suc c1 res", Result, 0);
        load_flags(4'b0000);
        run_op("suc c0", 14, 0, 0, 0, 0, 0);
        chk("suc c0 res", Result, 'hFFFF);

        run_op("asr3", 12, 'h8001, 0, 3, 0, 0);
        chk("asr3 res", Result, 'hF000);
        run_op("lsl1", 10, 'h8001, 0, 1, 0, 0);
        chk("lsl1 c", Flags[1], 1);
        run_op("lsr0", 11, 'h1234, 0, 0, 0, 0);

        // Ignored Start and FlagsWe while busy, then Flush
        pre_r = m_res; pre_f = m_fl;
        @(negedge Clock);
        Fn = 4'd11; A = W'($urandom); ShAmt = SW'(8); Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        chk("flush busy1", Busy, 1);
        @(negedge Clock);
        Start = 1'b1; Fn = 4'd5; FlagsWe = 1'b1; FlagsIn = ~m_fl;
        @(posedge Clock); #1;
        Start = 1'b0; FlagsWe = 1'b0;
        chk("flush busy2", Busy, 1);
        @(negedge Clock);
        Flush = 1'b1;
        @(posedge Clock); #1;
        Flush = 1'b0;
        chk("flush busy", Busy, 0);
        chk("flush done", Done, 0);
        chk("flush result", Result, pre_r);
        chk("flush flags", Flags, pre_f);
        @(posedge Clock); #1;
        chk("flush late done", Done, 0);

        // Flush and Start together: Start dropped
        @(negedge Clock);
        Start = 1'b1; Flush = 1'b1; Fn = 4'd5; A = 1; B = 1;
        @(posedge Clock); #1;
        Start = 1'b0; Flush = 1'b0;
        @(posedge Clock); #1;
        chk("flush+start done", Done, 0);
        chk("flush+start res", Result, pre_r);

        load_flags(4'b0000);
        run_op("adc we", 2, 1, 1, 0, 1, 4'b0010);
        chk("adc we res", Result, 2);
        chk("adc we flags", Flags, 4'b0000);

        // Back-to-back non-shift ops
        @(negedge Clock);
        Fn = 4'd5; A = W'(16'h1111); B = W'(16'h2222); Start = 1'b1;
        model(5, 'h1111, 'h2222, 0, 0, 0);
        r1 = m_res; f1 = m_fl;
        @(posedge Clock); #1;
        Fn = 4'd7; A = W'(16'h0FF0); B = W'(16'h00FF);
        model(7, 'h0FF0, 'h00FF, 0, 0, 0);
        @(posedge Clock); #1;
        Start = 1'b0;
        chk("b2b done1", Done, 1);
        chk("b2b res1", Result, r1);
        chk("b2b flags1", Flags, f1);
        @(posedge Clock); #1;
        chk("b2b done2", Done, 1);
        chk("b2b res2", Result, m_res);
        chk("b2b flags2", Flags, m_fl);

        for (int i = 0; i < 200; i++) begin
            run_op("rand", $urandom_range(0, 15), $urandom & MSK,
                   $urandom & MSK, $urandom_range(0, 6),
                   ($urandom % 4) == 0, 4'($urandom));
        end

        // Asynchronous reset in the middle of a shift
        @(negedge Clock);
        Fn = 4'd12; A = W'(16'hA5A5); ShAmt = SW'(10); Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock); #3;
        nReset = 1'b0;
        #1;
        chk("mid rst result", Result, 0);
        chk("mid rst flags", Flags, 0);
        chk("mid rst busy", Busy, 0);
        chk("mid rst done", Done, 0);
        @(negedge Clock);
        nReset = 1'b1;
        m_res = '0; m_fl = '0;
        @(posedge Clock); #1;
        chk("post rst done", Done, 0);
        run_op("post rst", 6, 3, 7, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
